// File: rtl/dmem_responder_if.sv
// Core-side MEM-stage request/response bundle for dmem_responder.
// master = pipeline MEM stage, slave = responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed wait states,
// byte-lane masked stores, sign/zero-extended loads, stall to the pipeline.
// Optional macro DMEM_ACCESS_COUNT_EN adds rd_count/wr_count outputs.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned ADDR_W = IDX_W + 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [31:0]         mem [DEPTH_WORDS];

  logic [IDX_W-1:0]    idx;
  logic [1:0]          lane;
  logic                err_c;
  logic [3:0]          be;
  logic [31:0]         wword;
  logic [31:0]         rword;
  logic [7:0]          rbyte;
  logic [15:0]         rhalf;
  logic [31:0]         load_val;
  logic                mem_we;
  logic                unused_addr_hi;

  assign idx            = addr_q[ADDR_W-1:2];
  assign lane           = addr_q[1:0];
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

  // Misalignment and illegal-size detection on the captured request
  always_comb begin
    err_c = 1'b0;
    case (funct3_q)
      3'b000, 3'b100: err_c = 1'b0;
      3'b001, 3'b101: err_c = lane[0];
      3'b010:         err_c = (lane != 2'b00);
      default:        err_c = 1'b1;
    endcase
    if (write_q && funct3_q[2]) err_c = 1'b1;
  end

  // Store lane enables and replicated write data
  always_comb begin
    be    = 4'b0000;
    wword = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata_q;
      end
    endcase
  end

  // Load lane select and extension
  always_comb begin
    rword = mem[idx];
    rbyte = rword[{lane, 3'b000} +: 8];
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_val = {24'd0, rbyte};
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_val = {16'd0, rhalf};
      default: load_val = rword;
    endcase
  end

  assign mem_we = (state_q == S_ACCESS) && write_q && !err_c;

  // Next-state, capture and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          addr_d   = bus.req_addr[ADDR_W-1:0];
          wdata_d  = bus.req_wdata;
          funct3_d = bus.req_funct3;
          cnt_d    = CNT_W'(WAIT_CYCLES);
          state_d  = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        rsp_err_d   = err_c;
        rsp_rdata_d = (write_q || err_c) ? 32'd0 : load_val;
        state_d     = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // Control and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage array, byte-lane write, never cleared
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  // Stall drops in RESP so the pipeline samples rsp_rdata on the advancing edge
  assign bus.stall     = ((state_q == S_IDLE) && bus.req_valid) ||
                         (state_q == S_WAIT) || (state_q == S_ACCESS);

`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // Count error-free accesses in their ACCESS cycle, wrapping at 2^32
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (state_q == S_ACCESS && !err_c) begin
      if (write_q) wr_count_d = wr_count_q + 32'd1;
      else         rd_count_d = rd_count_q + 32'd1;
    end
  end

  // Access counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, hand sequences for
// back-to-back, reset-in-WAIT and zero-wait latency, then random traffic
// against a byte-array reference model.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if ifc ();
  dmem_responder_if ifc0 ();

  logic        sel;
  logic        r_valid, r_write;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_f3;

  assign ifc.req_valid   = r_valid & ~sel;
  assign ifc.req_write   = r_write;
  assign ifc.req_addr    = r_addr;
  assign ifc.req_wdata   = r_wdata;
  assign ifc.req_funct3  = r_f3;
  assign ifc0.req_valid  = r_valid & sel;
  assign ifc0.req_write  = r_write;
  assign ifc0.req_addr   = r_addr;
  assign ifc0.req_wdata  = r_wdata;
  assign ifc0.req_funct3 = r_f3;

  logic        m_ready, m_rsp_valid, m_err, m_stall;
  logic [31:0] m_rdata;
  assign m_ready     = sel ? ifc0.req_ready : ifc.req_ready;
  assign m_rsp_valid = sel ? ifc0.rsp_valid : ifc.rsp_valid;
  assign m_rdata     = sel ? ifc0.rsp_rdata : ifc.rsp_rdata;
  assign m_err       = sel ? ifc0.rsp_err   : ifc.rsp_err;
  assign m_stall     = sel ? ifc0.stall     : ifc.stall;

`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rd_count, wr_count, rd_count0, wr_count0;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset), .bus(ifc)
`ifdef DMEM_ACCESS_COUNT_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(ifc0)
`ifdef DMEM_ACCESS_COUNT_EN
    , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] mem_m [DEPTH*4];
  int exp_rd = 0;
  int exp_wr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed array, size/alignment rules, extension by arithmetic
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int size;
    int base;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    er = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
         (w && (f3 == 3'd4 || f3 == 3'd5)) ||
         ((a[1:0] & 2'(size - 1)) != 2'd0);
    rd = 32'd0;
    if (!er) begin
      base = int'(a % (DEPTH * 4));
      if (w) begin
        for (int i = 0; i < size; i++) mem_m[base + i] = wd[8*i +: 8];
        exp_wr++;
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(mem_m[base + i]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        rd = v;
        exp_rd++;
      end
    end
  endfunction

  // Issue one request to the selected DUT and wait (bounded) for its response
  task automatic do_access(input logic s, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3, input logic hold,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int stl, output int iw);
    sel = s; r_write = w; r_addr = a; r_wdata = wd; r_f3 = f3; r_valid = 1'b1;
    #1;
    iw = 0;
    while (!m_ready && iw < 50) begin
      @(posedge clk); #1; iw++;
    end
    check("req_ready before accept", 32'(m_ready), 32'h1);
    check("stall on idle request", 32'(m_stall), 32'h1);
    @(posedge clk); #1;
    lat = 1; stl = 0;
    while (!m_rsp_valid && lat < 40) begin
      if (m_stall) stl++;
      @(posedge clk); #1; lat++;
    end
    check("rsp_valid within bound", 32'(m_rsp_valid), 32'h1);
    check("stall low in RESP", 32'(m_stall), 32'h0);
    rd = m_rdata;
    er = m_err;
    if (!hold) r_valid = 1'b0;
  endtask

  // Access on the WAIT_CYCLES=2 DUT checked against the reference model
  task automatic ref_access(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, stl, iw;
    do_access(1'b0, w, a, wd, f3, 1'b0, rd, er, lat, stl, iw);
    model(w, a, wd, f3, erd, eer);
    check({tag, " rdata"}, rd, erd);
    check({tag, " err"}, 32'(er), 32'(eer));
    check({tag, " latency"}, 32'(lat), 32'(WAITC + 2));
    check({tag, " stall cycles"}, 32'(stl), 32'(WAITC + 1));
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [22];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd, erd, a;
    logic er, eer, w;
    logic [2:0] f3;
    int lat, stl, iw;

    vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h11,  32'h80,       3'b000, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 32'h11,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
    vt[4]  = '{1'b0, 32'h11,  32'h0,        3'b100, 32'h00000080, 1'b0};
    vt[5]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD80EF, 1'b0};
    vt[6]  = '{1'b1, 32'h12,  32'h1234,     3'b001, 32'h0,        1'b0};
    vt[7]  = '{1'b0, 32'h12,  32'h0,        3'b101, 32'h00001234, 1'b0};
    vt[8]  = '{1'b0, 32'h13,  32'h0,        3'b001, 32'h0,        1'b1};
    vt[9]  = '{1'b1, 32'h14,  32'h11223344, 3'b010, 32'h0,        1'b0};
    vt[10] = '{1'b1, 32'h16,  32'hFFFFFFFF, 3'b010, 32'h0,        1'b1};
    vt[11] = '{1'b0, 32'h14,  32'h0,        3'b010, 32'h11223344, 1'b0};
    vt[12] = '{1'b1, 32'h400, 32'hA5A5A5A5, 3'b010, 32'h0,        1'b0};
    vt[13] = '{1'b0, 32'h0,   32'h0,        3'b010, 32'hA5A5A5A5, 1'b0};
    vt[14] = '{1'b0, 32'h10,  32'h0,        3'b010, 32'h123480EF, 1'b0};
    vt[15] = '{1'b0, 32'h12,  32'h0,        3'b011, 32'h0,        1'b1};
    vt[16] = '{1'b1, 32'h10,  32'hFFFFFFFF, 3'b100, 32'h0,        1'b1};
    vt[17] = '{1'b0, 32'h10,  32'h0,        3'b010, 32'h123480EF, 1'b0};
    vt[18] = '{1'b0, 32'h13,  32'h0,        3'b000, 32'h00000012, 1'b0};
    vt[19] = '{1'b0, 32'h12,  32'h0,        3'b001, 32'h00001234, 1'b0};
    vt[20] = '{1'b1, 32'h12,  32'hABCD,     3'b001, 32'h0,        1'b0};
    vt[21] = '{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFABCD, 1'b0};

    sel = 1'b0; r_valid = 1'b0; r_write = 1'b0; r_addr = '0; r_wdata = '0; r_f3 = '0;
    reset = 1'b0;
    #12;
    check("reset req_ready", 32'(ifc.req_ready), 32'h1);
    check("reset rsp_valid", 32'(ifc.rsp_valid), 32'h0);
    check("reset rsp_rdata", ifc.rsp_rdata, 32'h0);
    check("reset rsp_err", 32'(ifc.rsp_err), 32'h0);
    check("reset stall", 32'(ifc.stall), 32'h0);
`ifdef DMEM_ACCESS_COUNT_EN
    check("reset rd_count", rd_count, 32'h0);
    check("reset wr_count", wr_count, 32'h0);
`endif
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < int'(DEPTH); i++) ref_access("init", 1'b1, 32'(i * 4), $urandom, 3'b010);

    for (int i = 0; i < 22; i++) begin
      do_access(1'b0, vt[i].w, vt[i].addr, vt[i].wdata, vt[i].f3, 1'b0, rd, er, lat, stl, iw);
      model(vt[i].w, vt[i].addr, vt[i].wdata, vt[i].f3, erd, eer);
      check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vt[i].exp_err));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d stall cycles", i), 32'(stl), 32'd3);
    end

    // Back-to-back loads with req_valid held high
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 3'b010, 1'b1, rd, er, lat, stl, iw);
    model(1'b0, 32'h10, 32'h0, 3'b010, erd, eer);
    check("b2b first rdata", rd, erd);
    do_access(1'b0, 1'b0, 32'h14, 32'h0, 3'b010, 1'b0, rd, er, lat, stl, iw);
    model(1'b0, 32'h14, 32'h0, 3'b010, erd, eer);
    check("b2b idle cycles before accept", 32'(iw), 32'd1);
    check("b2b second latency", 32'(lat), 32'd4);
    check("b2b second rdata", rd, erd);

    // Reset during WAIT of a store: store dropped, outputs reset at once
    sel = 1'b0; r_write = 1'b1; r_addr = 32'h20; r_wdata = 32'hCAFEF00D; r_f3 = 3'b010;
    iw = 0;
    while (!ifc.req_ready && iw < 50) begin
      @(posedge clk); #1; iw++;
    end
    r_valid = 1'b1;
    @(posedge clk); #1;
    check("pre-reset stall in WAIT", 32'(ifc.stall), 32'h1);
    r_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid reset req_ready", 32'(ifc.req_ready), 32'h1);
    check("mid reset rsp_valid", 32'(ifc.rsp_valid), 32'h0);
    check("mid reset rsp_rdata", ifc.rsp_rdata, 32'h0);
    check("mid reset stall", 32'(ifc.stall), 32'h0);
`ifdef DMEM_ACCESS_COUNT_EN
    check("mid reset rd_count", rd_count, 32'h0);
    check("mid reset wr_count", wr_count, 32'h0);
    exp_rd = 0; exp_wr = 0;
`endif
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    ref_access("after dropped store", 1'b0, 32'h20, 32'h0, 3'b010);

    // Zero-wait instance: response two cycles after accept
    do_access(1'b1, 1'b1, 32'h8, 32'h55AA0011, 3'b010, 1'b0, rd, er, lat, stl, iw);
    check("w0 store latency", 32'(lat), 32'd2);
    check("w0 store err", 32'(er), 32'h0);
    check("w0 store rdata", rd, 32'h0);
    do_access(1'b1, 1'b0, 32'h8, 32'h0, 3'b010, 1'b0, rd, er, lat, stl, iw);
    check("w0 load latency", 32'(lat), 32'd2);
    check("w0 load stall cycles", 32'(stl), 32'd1);
    check("w0 load rdata", rd, 32'h55AA0011);
    do_access(1'b1, 1'b0, 32'hA, 32'h0, 3'b001, 1'b0, rd, er, lat, stl, iw);
    check("w0 lh upper", rd, 32'h000055AA);
    sel = 1'b0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1)      a[0] = 1'b0;
        else if (f3[1:0] != 2'd0) a[1:0] = 2'd0;
      end
      ref_access($sformatf("rand%0d", n), w, a, $urandom, f3);
    end

`ifdef DMEM_ACCESS_COUNT_EN
    check("rd_count", rd_count, 32'(exp_rd));
    check("wr_count", wr_count, 32'(exp_wr));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipelined RV32I core. It sits on the far side of the core's MEM-stage memory interface: it accepts one load or store request at a time and services it after a fixed number of wait states. Stores are byte-lane masked and loads are sign- or zero-extended. It drives a stall back to the hazard/pipeline-enable logic until it returns its response.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the storage array; must be a power of two, minimum 4.
WAIT_CYCLES, 2, wait states between request accept and response; legal range 0..15.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low (0 = reset asserted)
req_valid  in  1  MEM-stage access request (MemWriteM or load in MEM)
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address (ALUResultM)
req_wdata  in  32  store data (WriteDataM), right-aligned
req_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_ready  out  1  responder can accept a request this cycle
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  32  extended load data, valid with rsp_valid
rsp_err  out  1  misaligned address or illegal funct3, valid with rsp_valid
stall  out  1  holds the pipeline (StallF/StallD/StallE/StallM) while the access is outstanding

Behaviour:
- Reset (reset=0, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0, wait counter=0. The array is not cleared.
- States:
  - IDLE: req_ready=1. On req_valid=1, capture write, addr, wdata and funct3. Load counter with WAIT_CYCLES. If WAIT_CYCLES=0 go to ACCESS, else go to WAIT.
  - WAIT: req_ready=0. Decrement the counter each cycle. When counter==1, go to ACCESS.
  - ACCESS: perform the array read or write using the captured fields, register the result, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0, go to IDLE.
- Latency: rsp_valid rises WAIT_CYCLES+2 cycles after the accept edge (WAIT_CYCLES=2 gives 4).
- stall = (IDLE & req_valid) | WAIT | ACCESS. stall is 0 in RESP so the pipeline advances on the edge at which it samples rsp_rdata.
- req_* must be held stable by the core while stall=1. The responder ignores the inputs after capture.
- A request present in the cycle after RESP (back-to-back) is accepted normally from IDLE. There is no bubble beyond RESP.
- Index: word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Stores:
  - sb writes byte lane addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - sw writes all four lanes.
  - Other lanes are unchanged. rsp_rdata=0 on store responses.
- Loads: select the byte or half by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw returns the whole word.
- Errors: any of the following sets rsp_err=1, suppresses the array write, and forces rsp_rdata=0. Latency is unchanged.
  - half access with addr[0]=1
  - word access with addr[1:0]≠0
  - funct3 ∈ {011, 110, 111}
  - store funct3 ∈ {100, 101}
- Reset asserted mid-access returns the block to IDLE immediately. A store not yet in ACCESS is dropped; a store already written stays written.

Optional Feature:
DMEM_ACCESS_COUNT_EN
- Defined:
  - Adds outputs rd_count[31:0] and wr_count[31:0]; both are 0 on reset.
  - Each increments by 1 in the ACCESS cycle of an error-free load or store, respectively, and wraps from 0xFFFFFFFF to 0.
  - Errored accesses are not counted.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
1. WAIT_CYCLES=2; sw addr=0x10 wdata=0xDEADBEEF, then lw 0x10 -> store rsp_valid at cycle 4 after accept, rsp_err=0; load rsp_rdata=0xDEADBEEF; stall high for 3 cycles per access.
2. After test 1, sb addr=0x11 wdata=0x80, then lb 0x11 -> 0xFFFFFF80; lbu 0x11 -> 0x00000080; lw 0x10 -> 0xDEAD80EF.
3. sh 0x12 wdata=0x1234 then lhu 0x12 -> 0x00001234. lh 0x13 -> rsp_err=1, rdata=0. sw 0x16 -> rsp_err=1, word 0x14 unchanged.
4. DEPTH_WORDS=256: sw 0x400 wdata=0xA5A5A5A5 then lw 0x0 -> 0xA5A5A5A5 (wrap). WAIT_CYCLES=0: rsp_valid 2 cycles after accept.
5. Back-to-back: req_valid held high across two different loads -> two rsp_valid pulses with req_ready=1 in the IDLE cycle between them. Then assert reset=0 in WAIT of a sw to 0x20 -> outputs reset immediately and lw 0x20 returns the old value.
6. With DMEM_ACCESS_COUNT_EN: 3 good loads, 2 good stores, 1 misaligned store -> rd_count=3, wr_count=2. Reset -> both 0.
